// File: rtl/ber_pkg.sv
// rtl/ber_pkg.sv - shared constants, state encoding and helpers for ber_checker
//
// Purpose: PRBS9 length and taps, default seed, checker state encoding,
//          count width and the window-counter width helper.

package ber_pkg;

  localparam int PRBS_ORDER   = 9;
  localparam int PRBS_LEN     = 511;
  localparam int PRBS_TAP_OUT = 8;
  localparam int PRBS_TAP_FB  = 4;

  localparam logic [PRBS_ORDER-1:0] SEED_DEFAULT = 9'h1AA;

  localparam int CNT_W = 64;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_e;

  // Width able to hold a count of 0..win_len inclusive.
  function automatic int win_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage

// File: rtl/prbs9_gen.sv
// rtl/prbs9_gen.sv - PRBS9 (x^9+x^5+1) Fibonacci reference generator
//
// Purpose: local replica of the transmitted PRBS9 sequence.
// Ports:
//   i_clock  - DSP clock
//   i_reset  - synchronous active-high reset, loads SEED
//   i_enbl   - symbol strobe; the register only moves on strobe cycles
//   i_hold   - suppress the advance on this strobe (phase slip)
//   o_bit    - current reference bit, reg[8]

module prbs9_gen
  import ber_pkg::*;
#(
  parameter logic [PRBS_ORDER-1:0] SEED = SEED_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enbl,
  input  logic i_hold,
  output logic o_bit
);

  logic [PRBS_ORDER-1:0] prbs_q;
  logic [PRBS_ORDER-1:0] prbs_d;

  always_comb begin
    prbs_d = prbs_q;
    if (i_enbl && !i_hold) begin
      prbs_d = {prbs_q[PRBS_ORDER-2:0], prbs_q[PRBS_TAP_OUT] ^ prbs_q[PRBS_TAP_FB]};
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prbs_q <= SEED;
    end else begin
      prbs_q <= prbs_d;
    end
  end

  assign o_bit = prbs_q[PRBS_TAP_OUT];

endmodule

// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - per-branch PRBS9 bit-error-rate checker with slip alignment
//
// Purpose: aligns a local PRBS9 replica to the slicer decisions by slipping
//          the replica one symbol per failed window, then accumulates
//          saturating 64-bit bit/error counts while locked.
// Optional feature: define BER_RELOCK_EN to run a monitor window while
//          LOCKED that drops back to SEARCH when window errors exceed
//          RELOCK_THR.
// Ports:
//   i_clock      - DSP clock
//   i_reset      - synchronous active-high reset
//   i_enbl       - symbol-rate strobe; sampling state only advances on it
//   i_rx_bit     - slicer decision bit
//   i_resync     - force return to SEARCH (counters and phase hold)
//   i_clear      - zero both counters
//   o_count_bit  - compared bits while locked (saturating)
//   o_count_err  - bit errors while locked (saturating)
//   o_locked     - alignment achieved
//   o_phase      - slips performed, modulo 511

module ber_checker
  import ber_pkg::*;
#(
  parameter int                    WIN_LEN    = 511,
  parameter int                    SYNC_THR   = 0,
  parameter int                    RELOCK_THR = 128,
  parameter logic [PRBS_ORDER-1:0] SEED       = SEED_DEFAULT
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enbl,
  input  logic             i_rx_bit,
  input  logic             i_resync,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count_bit,
  output logic [CNT_W-1:0] o_count_err,
  output logic             o_locked,
  output logic [8:0]       o_phase
);

  localparam int               WIN_W      = win_width(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WIN_LEN - 1);
  localparam logic [WIN_W:0]   SYNC_LIM   = (WIN_W + 1)'(SYNC_THR);
  localparam logic [8:0]       PHASE_LAST = 9'(PRBS_LEN - 1);

  ber_state_e       state_q, state_d;
  logic             locked_q, locked_d;
  logic             slip_q, slip_d;
  logic [WIN_W-1:0] win_bits_q, win_bits_d;
  logic [WIN_W-1:0] win_errs_q, win_errs_d;
  logic [8:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_bit_q, cnt_bit_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

  logic             ref_bit;
  logic             err;
  logic             prbs_hold;
  logic             win_end;
  logic [WIN_W:0]   win_errs_sum;

  // A pending slip swallows exactly one strobe: the replica stands still
  // while the received stream moves on, delaying the replica by one symbol.
  assign prbs_hold = (state_q == SEARCH) && slip_q;

  prbs9_gen #(
    .SEED (SEED)
  ) u_prbs (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enbl  (i_enbl),
    .i_hold  (prbs_hold),
    .o_bit   (ref_bit)
  );

  assign err          = i_rx_bit ^ ref_bit;
  assign win_end      = (win_bits_q == WIN_LAST);
  // Includes the sample of the current strobe, so the window total is
  // complete on the strobe that finishes it.
  assign win_errs_sum = {1'b0, win_errs_q} + {{WIN_W{1'b0}}, err};

`ifdef BER_RELOCK_EN
  localparam logic [WIN_W:0] RELOCK_LIM = (WIN_W + 1)'(RELOCK_THR);
`else
  // The threshold only matters to the monitor window; a value at or above
  // the window length could never trip it.
  if (RELOCK_THR >= WIN_LEN) begin : g_relock_thr_unreachable
  end
`endif

  always_comb begin
    state_d    = state_q;
    locked_d   = locked_q;
    slip_d     = slip_q;
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
    phase_d    = phase_q;
    cnt_bit_d  = cnt_bit_q;
    cnt_err_d  = cnt_err_q;

    if (i_enbl) begin
      case (state_q)
        SEARCH: begin
          if (slip_q) begin
            slip_d = 1'b0;
          end else if (win_end) begin
            win_bits_d = '0;
            win_errs_d = '0;
            if (win_errs_sum <= SYNC_LIM) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              slip_d  = 1'b1;
              phase_d = (phase_q == PHASE_LAST) ? 9'd0 : phase_q + 9'd1;
            end
          end else begin
            win_bits_d = win_bits_q + 1'b1;
            win_errs_d = win_errs_sum[WIN_W-1:0];
          end
        end
        LOCKED: begin
          if (cnt_bit_q != {CNT_W{1'b1}}) begin
            cnt_bit_d = cnt_bit_q + 1'b1;
          end
          if (err && (cnt_err_q != {CNT_W{1'b1}})) begin
            cnt_err_d = cnt_err_q + 1'b1;
          end
`ifdef BER_RELOCK_EN
          if (win_end) begin
            win_bits_d = '0;
            win_errs_d = '0;
            if (win_errs_sum > RELOCK_LIM) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
            end
          end else begin
            win_bits_d = win_bits_q + 1'b1;
            win_errs_d = win_errs_sum[WIN_W-1:0];
          end
`endif
        end
        default: state_d = SEARCH;
      endcase
    end

    // Software commands act whether or not a strobe is present; clear
    // discards any coincident sample.
    if (i_clear) begin
      cnt_bit_d = '0;
      cnt_err_d = '0;
    end

    if (i_resync) begin
      state_d    = SEARCH;
      locked_d   = 1'b0;
      slip_d     = 1'b0;
      win_bits_d = '0;
      win_errs_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= SEARCH;
      locked_q   <= 1'b0;
      slip_q     <= 1'b0;
      win_bits_q <= '0;
      win_errs_q <= '0;
      phase_q    <= '0;
      cnt_bit_q  <= '0;
      cnt_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      slip_q     <= slip_d;
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
      phase_q    <= phase_d;
      cnt_bit_q  <= cnt_bit_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign o_count_bit = cnt_bit_q;
  assign o_count_err = cnt_err_q;
  assign o_locked    = locked_q;
  assign o_phase     = phase_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - directed self-checking bench for ber_checker

module tb_ber_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rx;
  logic        rsy;
  logic        clr;
  logic [63:0] cb;
  logic [63:0] ce;
  logic        lk;
  logic [8:0]  ph;

  int   passed = 0;
  int   total  = 0;
  int   failed = 0;
  int   n;
  logic seq [511];

  always #5 clk = ~clk;

  ber_checker dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_enbl      (en),
    .i_rx_bit    (rx),
    .i_resync    (rsy),
    .i_clear     (clr),
    .o_count_bit (cb),
    .o_count_err (ce),
    .o_locked    (lk),
    .o_phase     (ph)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic r, input logic c, input logic s);
    en  = e;
    rx  = r;
    clr = c;
    rsy = s;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    rsy = 1'b0;
  endtask

  // Received stream lags the replica by 37 symbols (index n-37 mod 511).
  function automatic logic rx_bit_now();
    return seq[(n + 474) % 511];
  endfunction

  task automatic run_aligned(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick(1'b1, rx_bit_now(), 1'b0, 1'b0);
      n++;
    end
  endtask

  // 37 failed windows + 37 slip strobes + 1 clean window = 19455 strobes.
  task automatic search_to_lock(input string pfx);
    run_aligned(19454);
    chk({pfx, "_prelock"}, 64'(lk), 64'd0);
    chk({pfx, "_phase"}, 64'(ph), 64'd37);
    run_aligned(1);
    chk({pfx, "_locked"}, 64'(lk), 64'd1);
    chk({pfx, "_bits0"}, cb, 64'd0);
    chk({pfx, "_errs0"}, ce, 64'd0);
  endtask

  initial begin
    logic [8:0] r;
    logic       b;

    rst = 1'b1;
    en  = 1'b0;
    rx  = 1'b0;
    clr = 1'b0;
    rsy = 1'b0;

    r = 9'h1AA;
    for (int i = 0; i < 511; i++) begin
      seq[i] = r[8];
      r = {r[7:0], r[8] ^ r[4]};
    end

    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_locked", 64'(lk), 64'd0);
    chk("rst_phase", 64'(ph), 64'd0);
    chk("rst_bits", cb, 64'd0);
    chk("rst_errs", ce, 64'd0);
    chk("rst_prbs", 64'(dut.u_prbs.prbs_q), 64'h1AA);
    rst = 1'b0;

    // Scenario 1: slip search to lock.
    n = 0;
    search_to_lock("s1");

    // Scenario 2: one flipped bit in every hundred.
    for (int k = 0; k < 10000; k++) begin
      b = rx_bit_now();
      if ((k % 100) == 99) b = ~b;
      tick(1'b1, b, 1'b0, 1'b0);
      n++;
    end
    chk("s2_bits", cb, 64'd10000);
    chk("s2_errs", ce, 64'd100);

    // Scenario 3: strobe every other clock; garbage rx on idle clocks.
    for (int k = 0; k < 2000; k++) begin
      if ((k % 2) == 0) begin
        tick(1'b1, rx_bit_now(), 1'b0, 1'b0);
        n++;
      end else begin
        tick(1'b0, ~rx_bit_now(), 1'b0, 1'b0);
      end
      if (k == 1 || k == 3) chk("s3_bits_idle", cb, 64'(10000 + (k + 1) / 2));
    end
    chk("s3_bits", cb, 64'd11000);
    chk("s3_errs", ce, 64'd100);

    // Scenario 4: clear coincident with an erroneous sample.
    tick(1'b1, ~rx_bit_now(), 1'b1, 1'b0);
    n++;
    chk("s4_clr_bits", cb, 64'd0);
    chk("s4_clr_errs", ce, 64'd0);
    tick(1'b1, rx_bit_now(), 1'b0, 1'b0);
    n++;
    chk("s4_bits", cb, 64'd1);
    chk("s4_errs", ce, 64'd0);

    // Resync: counters and phase hold, one clean window relocks.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rsy_locked", 64'(lk), 64'd0);
    chk("rsy_bits", cb, 64'd1);
    chk("rsy_errs", ce, 64'd0);
    chk("rsy_phase", 64'(ph), 64'd37);
    run_aligned(510);
    chk("rsy_prelock", 64'(lk), 64'd0);
    run_aligned(1);
    chk("rsy_relocked", 64'(lk), 64'd1);
    chk("rsy_bits_held", cb, 64'd1);
    chk("rsy_phase_held", 64'(ph), 64'd37);

    // Scenario 5: a window of random decisions.
    for (int k = 0; k < 511; k++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n++;
    end
    chk("s5_bits", cb, 64'd512);
`ifdef BER_RELOCK_EN
    chk("s5_dropped", 64'(lk), 64'd0);
    run_aligned(20);
    chk("s5_bits_frozen", cb, 64'd512);
    chk("s5_still_search", 64'(lk), 64'd0);
`else
    chk("s5_held_lock", 64'(lk), 64'd1);
    chk("s5_err_range", 64'((ce >= 64'd200) && (ce <= 64'd310)), 64'd1);
`endif

    // Scenario 6: reset mid-search at phase 12, then full reacquisition.
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    n = 0;
    run_aligned(6143 + 100);
    chk("s6_phase12", 64'(ph), 64'd12);
    chk("s6_search", 64'(lk), 64'd0);
    rst = 1'b1;
    tick(1'b1, rx_bit_now(), 1'b0, 1'b0);
    rst = 1'b0;
    chk("s6_rst_phase", 64'(ph), 64'd0);
    chk("s6_rst_locked", 64'(lk), 64'd0);
    chk("s6_rst_bits", cb, 64'd0);
    chk("s6_rst_prbs", 64'(dut.u_prbs.prbs_q), 64'h1AA);
    n = 0;
    search_to_lock("s6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
